// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, sequencer states and status byte layout
package alu_pkg;

    localparam logic [7:0] OP_ADD = 8'h20;
    localparam logic [7:0] OP_SUB = 8'h22;
    localparam logic [7:0] OP_AND = 8'h24;
    localparam logic [7:0] OP_OR  = 8'h25;
    localparam logic [7:0] OP_XOR = 8'h26;
    localparam logic [7:0] OP_NOR = 8'h27;
    localparam logic [7:0] OP_SRL = 8'h02;
    localparam logic [7:0] OP_SRA = 8'h03;

    localparam int STAT_ZERO_BIT   = 0;
    localparam int STAT_CARRY_BIT  = 1;
    localparam int STAT_OP_ERR_BIT = 7;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_CHECK   = 3'd3,
        ST_TX_RES  = 3'd4,
        ST_TX_STAT = 3'd5
    } state_t;

    function automatic logic is_valid_op(input logic [7:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRL, OP_SRA: is_valid_op = 1'b1;
            default:                        is_valid_op = 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] make_status(input logic zero, input logic carry, input logic op_err);
        logic [7:0] s;
        s                  = 8'h00;
        s[STAT_ZERO_BIT]   = zero;
        s[STAT_CARRY_BIT]  = carry;
        s[STAT_OP_ERR_BIT] = op_err;
        return s;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - saturating inter-byte gap counter with expiry flag
module frame_timer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired = (cnt_q == LAST);

    // Count idle cycles; hold at the last value so the counter never wraps
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Gap counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_alu_sequencer.sv
// rtl/uart_alu_sequencer.sv - collects A/B/OP bytes, runs the ALU and sends result and status
module uart_alu_sequencer
    import alu_pkg::*;
#(
    parameter int NB_BITS        = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NB_BITS-1:0] i_rx_data,
    input  logic               i_rx_valid,
    input  logic [NB_BITS-1:0] i_alu_result,
    input  logic               i_alu_zero,
    input  logic               i_alu_carry,
    input  logic               i_tx_done,
    output logic [NB_BITS-1:0] o_A,
    output logic [NB_BITS-1:0] o_B,
    output logic [NB_BITS-1:0] o_OP,
    output logic               o_tx_start,
    output logic [NB_BITS-1:0] o_tx_data,
    output logic               o_busy,
    output logic               o_frame_err,
    output logic [7:0]         o_drop_cnt
);

    state_t state_q, state_d;

    logic [NB_BITS-1:0] a_q, a_d;
    logic [NB_BITS-1:0] b_q, b_d;
    logic [NB_BITS-1:0] op_q, op_d;
    logic               tx_start_q, tx_start_d;
    logic [NB_BITS-1:0] tx_data_q, tx_data_d;
    logic               busy_q, busy_d;
    logic               frame_err_q, frame_err_d;
    logic [7:0]         drop_q, drop_d;
    // Flags captured in CHECK; the captured result lives in tx_data_q
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               op_err_q, op_err_d;

    logic op_valid;
    logic in_gap;
    logic in_busy;
    logic timer_expired;

    // Opcodes are 8-bit codes; any set bit above them makes the opcode invalid
    assign op_valid = ((op_q >> 8) == '0) && is_valid_op(op_q[7:0]);
    assign in_gap   = (state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP);
    assign in_busy  = (state_q == ST_CHECK) || (state_q == ST_TX_RES) || (state_q == ST_TX_STAT);

    // Held at zero outside WAIT_B/WAIT_OP, so entry from WAIT_A starts from zero
    frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (!in_gap || i_rx_valid),
        .enable (in_gap),
        .expired(timer_expired)
    );

    // State and output registers; reset overrides every pending event
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_WAIT_A;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            drop_q      <= 8'h00;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            op_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            drop_q      <= drop_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            op_err_q    <= op_err_d;
        end
    end

    // Next state: a received byte takes priority over a simultaneous timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_A: begin
                if (i_rx_valid) state_d = ST_WAIT_B;
            end
            ST_WAIT_B: begin
                if (i_rx_valid)         state_d = ST_WAIT_OP;
                else if (timer_expired) state_d = ST_WAIT_A;
            end
            ST_WAIT_OP: begin
                if (i_rx_valid)         state_d = ST_CHECK;
                else if (timer_expired) state_d = ST_WAIT_A;
            end
            ST_CHECK: begin
                state_d = op_valid ? ST_TX_RES : ST_TX_STAT;
            end
            ST_TX_RES: begin
                if (i_tx_done) state_d = ST_TX_STAT;
            end
            ST_TX_STAT: begin
                if (i_tx_done) state_d = ST_WAIT_A;
            end
            default: state_d = ST_WAIT_A;
        endcase
    end

    // Next values of the registered outputs and captured flags
    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        frame_err_d = 1'b0;
        drop_d      = drop_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        op_err_d    = op_err_q;
        busy_d      = (state_d == ST_CHECK) || (state_d == ST_TX_RES) || (state_d == ST_TX_STAT);

        if (in_busy && i_rx_valid && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end

        case (state_q)
            ST_WAIT_A: begin
                if (i_rx_valid) a_d = i_rx_data;
            end
            ST_WAIT_B: begin
                if (i_rx_valid)         b_d = i_rx_data;
                else if (timer_expired) frame_err_d = 1'b1;
            end
            ST_WAIT_OP: begin
                if (i_rx_valid)         op_d = i_rx_data;
                else if (timer_expired) frame_err_d = 1'b1;
            end
            ST_CHECK: begin
                // An invalid opcode reports only op_err; the ALU flags are meaningless then
                zero_d     = op_valid && i_alu_zero;
                carry_d    = op_valid && i_alu_carry;
                op_err_d   = !op_valid;
                tx_start_d = 1'b1;
                tx_data_d  = op_valid ? i_alu_result
                                      : NB_BITS'(make_status(1'b0, 1'b0, 1'b1));
            end
            ST_TX_RES: begin
                if (i_tx_done) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = NB_BITS'(make_status(zero_q, carry_q, op_err_q));
                end
            end
            default: ;
        endcase
    end

    assign o_A         = a_q;
    assign o_B         = b_q;
    assign o_OP        = op_q;
    assign o_tx_start  = tx_start_q;
    assign o_tx_data   = tx_data_q;
    assign o_busy      = busy_q;
    assign o_frame_err = frame_err_q;
    assign o_drop_cnt  = drop_q;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// tb/tb_uart_alu_sequencer.sv - directed self-checking bench for uart_alu_sequencer
module tb_uart_alu_sequencer;
    import alu_pkg::*;

    localparam int NB = 8;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NB-1:0] rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          tx_done = 1'b0;
    logic [NB-1:0] alu_result;
    logic          alu_zero;
    logic          alu_carry;
    logic [NB-1:0] o_A, o_B, o_OP, o_tx_data;
    logic          o_tx_start, o_busy, o_frame_err;
    logic [7:0]    o_drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int tx_cnt   = 0;
    int ferr_cnt = 0;

    always #5 clk = ~clk;

    uart_alu_sequencer #(
        .NB_BITS(NB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .i_alu_result(alu_result),
        .i_alu_zero  (alu_zero),
        .i_alu_carry (alu_carry),
        .i_tx_done   (tx_done),
        .o_A         (o_A),
        .o_B         (o_B),
        .o_OP        (o_OP),
        .o_tx_start  (o_tx_start),
        .o_tx_data   (o_tx_data),
        .o_busy      (o_busy),
        .o_frame_err (o_frame_err),
        .o_drop_cnt  (o_drop_cnt)
    );

    // Reference ALU; carry is carry-out for ADD and borrow for SUB
    logic [8:0] wide;
    always_comb begin
        wide = '0;
        case (o_OP)
            OP_ADD: wide = {1'b0, o_A} + {1'b0, o_B};
            OP_SUB: wide = {1'b0, o_A} - {1'b0, o_B};
            OP_AND: wide = {1'b0, o_A & o_B};
            OP_OR:  wide = {1'b0, o_A | o_B};
            OP_XOR: wide = {1'b0, o_A ^ o_B};
            OP_NOR: wide = {1'b0, ~(o_A | o_B)};
            OP_SRL: wide = {1'b0, o_A >> o_B[2:0]};
            OP_SRA: wide = {1'b0, $signed(o_A) >>> o_B[2:0]};
            default: wide = '0;
        endcase
        alu_result = wide[7:0];
        alu_carry  = wide[8];
        alu_zero   = (wide[7:0] == 8'h00);
    end

    always @(negedge clk) begin
        if (o_tx_start)  tx_cnt++;
        if (o_frame_err) ferr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_tx_done();
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op, input bit has_res,
                             input logic [7:0] res, input logic [7:0] stat);
        int tx0;
        tx0 = tx_cnt;
        send_byte(a);
        send_byte(b);
        send_byte(op);
        check({tag, ".busy_in_check"}, o_busy, 1);
        @(negedge clk);
        check({tag, ".start1"}, o_tx_start, 1);
        check({tag, ".data1"}, o_tx_data, has_res ? res : stat);
        @(negedge clk);
        check({tag, ".start1_pulse"}, o_tx_start, 0);
        if (has_res) begin
            pulse_tx_done();
            check({tag, ".start2"}, o_tx_start, 1);
            check({tag, ".status"}, o_tx_data, stat);
            @(negedge clk);
            check({tag, ".status_held"}, o_tx_data, stat);
        end
        check({tag, ".busy_tx"}, o_busy, 1);
        pulse_tx_done();
        check({tag, ".busy_done"}, o_busy, 0);
        check({tag, ".tx_count"}, tx_cnt - tx0, has_res ? 2 : 1);
    endtask

    initial begin
        int first;
        int pulses;
        int tx0;

        // Outputs held low while reset is asserted
        repeat (3) @(negedge clk);
        check("rst.tx_start", o_tx_start, 0);
        check("rst.busy", o_busy, 0);
        check("rst.frame_err", o_frame_err, 0);
        check("rst.A", o_A, 0);
        check("rst.tx_data", o_tx_data, 0);
        check("rst.drop", o_drop_cnt, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst.busy", o_busy, 0);

        run_frame("add", 8'h05, 8'h03, 8'h20, 1'b1, 8'h08, 8'h00);
        run_frame("sub_zero", 8'h05, 8'h05, 8'h22, 1'b1, 8'h00, 8'h01);
        run_frame("add_carry", 8'hF0, 8'h20, 8'h20, 1'b1, 8'h10, 8'h02);
        run_frame("bad_op", 8'h01, 8'h02, 8'h3F, 1'b0, 8'h00, 8'h80);
        run_frame("sra", 8'h80, 8'h02, 8'h03, 1'b1, 8'hE0, 8'h00);

        // A stray tx_done in WAIT_A must not trigger anything
        tx0 = tx_cnt;
        pulse_tx_done();
        repeat (2) @(negedge clk);
        check("idle_done.tx", tx_cnt - tx0, 0);
        check("idle_done.busy", o_busy, 0);

        // Timeout: one frame_err exactly TO cycles after the last accepted byte
        send_byte(8'h07);
        first  = -1;
        pulses = 0;
        for (int j = 1; j <= TO + 5; j++) begin
            @(negedge clk);
            if (o_frame_err) begin
                pulses++;
                if (first < 0) first = j;
            end
        end
        check("timeout.when", first, TO);
        check("timeout.pulses", pulses, 1);
        check("timeout.A_kept", o_A, 8'h07);
        check("timeout.busy", o_busy, 0);
        run_frame("after_timeout", 8'h02, 8'h03, 8'h20, 1'b1, 8'h05, 8'h00);

        // Byte landing in the very cycle the timer expires is accepted
        send_byte(8'h09);
        repeat (TO - 2) @(negedge clk);
        send_byte(8'h04);
        check("race.B", o_B, 8'h04);
        check("race.no_err", ferr_cnt, 1);
        send_byte(8'h20);
        @(negedge clk);
        check("race.start", o_tx_start, 1);
        check("race.result", o_tx_data, 8'h0D);
        pulse_tx_done();
        pulse_tx_done();
        check("race.busy_done", o_busy, 0);

        // Bytes dropped while busy: count saturates, operands untouched
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h20);
        for (int k = 0; k < 300; k++) begin
            send_byte(8'hAA);
            if (k == 9) check("drop.ten", o_drop_cnt, 10);
        end
        check("drop.sat", o_drop_cnt, 255);
        check("drop.A", o_A, 8'h05);
        check("drop.B", o_B, 8'h03);
        check("drop.OP", o_OP, 8'h20);
        pulse_tx_done();
        pulse_tx_done();
        check("drop.busy_done", o_busy, 0);

        // Reset in TX_RES clears everything and leaves no pending pulse
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h20);
        @(negedge clk);
        check("mid_rst.started", o_tx_start, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst.busy", o_busy, 0);
        check("mid_rst.tx_start", o_tx_start, 0);
        check("mid_rst.tx_data", o_tx_data, 0);
        check("mid_rst.ops", {o_A, o_B, o_OP}, 0);
        check("mid_rst.drop", o_drop_cnt, 0);
        tx0 = tx_cnt;
        pulse_tx_done();
        repeat (2) @(negedge clk);
        check("mid_rst.late_done", tx_cnt - tx0, 0);
        check("mid_rst.idle", o_busy, 0);
        run_frame("after_rst", 8'h0C, 8'h0A, 8'h26, 1'b1, 8'h06, 8'h00);

        check("frame_err.total", ferr_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
